wb_bridge_32to16: RTL and testbench

Downstream consumer of the 16-bit boot ROM and other 16-bit Wishbone slaves. Converts one 32-bit Wishbone classic master cycle (CPU instruction/data port) into up to two 16-bit slave cycles, low halfword first. Assembles read data into a 32-bit word and splits write data by byte lanes. Adds a bounded wait-state timeout so a dead slave cannot hang the CPU.

---
 rtl/wb_pkg.sv | 12 +
 rtl/wb_wait_timer.sv | 26 ++
 rtl/wb_bridge_32to16.sv | 110 +++++++++++
 tb/tb_wb_bridge_32to16.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared state encoding for the 32-to-16 Wishbone bridge.
package wb_pkg;

  localparam int ST_W = 3;

  localparam logic [ST_W-1:0] ST_IDLE = 3'd0;
  localparam logic [ST_W-1:0] ST_LO   = 3'd1;
  localparam logic [ST_W-1:0] ST_HI   = 3'd2;
  localparam logic [ST_W-1:0] ST_DONE = 3'd3;
  localparam logic [ST_W-1:0] ST_ERR  = 3'd4;

endpackage

// File: rtl/wb_wait_timer.sv
// Wait-state counter for a slave half-cycle; tc_o flags the timeout terminal count.
module wb_wait_timer #(
  parameter int CW       = 4,
  parameter int WAIT_MAX = 15
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [CW-1:0] TERM = CW'(WAIT_MAX);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni)  cnt <= '0;
    else if (clr_i) cnt <= '0;
    else if (en_i)  cnt <= cnt + 1'b1;
  end

  // WAIT_MAX of zero means wait forever
  assign tc_o = (WAIT_MAX != 0) && (cnt == TERM);

endmodule

// File: rtl/wb_bridge_32to16.sv
// Splits one 32-bit Wishbone classic cycle into up to two 16-bit slave cycles, low half first.
module wb_bridge_32to16
  import wb_pkg::*;
#(
  parameter int AW       = 8,
  parameter int WAIT_MAX = 15,
  parameter int CW       = 4
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  input  logic [AW-3:0] m_adr_i,
  input  logic          m_cyc_i,
  input  logic          m_stb_i,
  input  logic          m_we_i,
  input  logic [3:0]    m_sel_i,
  input  logic [31:0]   m_dat_i,
  output logic          m_ack_o,
  output logic          m_err_o,
  output logic [31:0]   m_dat_o,
  output logic [AW-2:0] s_adr_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  output logic [1:0]    s_sel_o,
  output logic [15:0]   s_dat_o,
  input  logic          s_ack_i,
  input  logic [15:0]   s_dat_i
);

  logic [ST_W-1:0] state, state_nxt;
  logic [AW-3:0]   adr_q;
  logic            we_q;
  logic [3:0]      sel_q;
  logic [31:0]     wdat_q;
  logic [31:0]     rdat_q;
  logic            req, active, is_hi, tc;

  assign req    = m_cyc_i & m_stb_i;
  assign active = (state == ST_LO) || (state == ST_HI);
  assign is_hi  = (state == ST_HI);

  wb_wait_timer #(
    .CW       (CW),
    .WAIT_MAX (WAIT_MAX)
  ) u_timer (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .clr_i    (!active || s_ack_i),
    .en_i     (active && !s_ack_i),
    .tc_o     (tc)
  );

  // Abort beats ack, ack beats timeout
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (req) begin
        if (|m_sel_i[1:0])      state_nxt = ST_LO;
        else if (|m_sel_i[3:2]) state_nxt = ST_HI;
        else                    state_nxt = ST_DONE;
      end
      ST_LO: begin
        if (!m_cyc_i)    state_nxt = ST_IDLE;
        else if (s_ack_i) state_nxt = (|sel_q[3:2]) ? ST_HI : ST_DONE;
        else if (tc)      state_nxt = ST_ERR;
      end
      ST_HI: begin
        if (!m_cyc_i)    state_nxt = ST_IDLE;
        else if (s_ack_i) state_nxt = ST_DONE;
        else if (tc)      state_nxt = ST_ERR;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state  <= ST_IDLE;
      adr_q  <= '0;
      we_q   <= 1'b0;
      sel_q  <= '0;
      wdat_q <= '0;
      rdat_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && req) begin
        adr_q  <= m_adr_i;
        we_q   <= m_we_i;
        sel_q  <= m_sel_i;
        wdat_q <= m_dat_i;
        rdat_q <= '0;
      end else if (active && s_ack_i && !we_q) begin
        if (is_hi) rdat_q[31:16] <= s_dat_i;
        else       rdat_q[15:0]  <= s_dat_i;
      end
    end
  end

  assign s_cyc_o = active;
  assign s_stb_o = active;
  assign s_we_o  = active & we_q;
  assign s_adr_o = active ? {adr_q, is_hi} : '0;
  assign s_sel_o = active ? (is_hi ? sel_q[3:2] : sel_q[1:0]) : 2'b00;
  assign s_dat_o = active ? (is_hi ? wdat_q[31:16] : wdat_q[15:0]) : 16'h0000;

  assign m_ack_o = (state == ST_DONE);
  assign m_err_o = (state == ST_ERR);
  assign m_dat_o = m_ack_o ? rdat_q : 32'h0;

endmodule

// File: tb/tb_wb_bridge_32to16.sv
// Bench for wb_bridge_32to16: directed boot-ROM cases plus random traffic against a word-level model.
module tb_wb_bridge_32to16;

  localparam int AW       = 8;
  localparam int WAIT_MAX = 15;
  localparam int CW       = 4;

  logic          clk_i = 1'b0;
  logic          reset_ni = 1'b0;
  logic [AW-3:0] m_adr_i = '0;
  logic          m_cyc_i = 1'b0;
  logic          m_stb_i = 1'b0;
  logic          m_we_i = 1'b0;
  logic [3:0]    m_sel_i = '0;
  logic [31:0]   m_dat_i = '0;
  logic          m_ack_o, m_err_o;
  logic [31:0]   m_dat_o;
  logic [AW-2:0] s_adr_o;
  logic          s_cyc_o, s_stb_o, s_we_o;
  logic [1:0]    s_sel_o;
  logic [15:0]   s_dat_o;
  logic          s_ack_i;
  logic [15:0]   s_dat_i;

  always #5 clk_i = ~clk_i;

  wb_bridge_32to16 #(.AW(AW), .WAIT_MAX(WAIT_MAX), .CW(CW)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .m_adr_i(m_adr_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_sel_i(m_sel_i), .m_dat_i(m_dat_i), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .m_dat_o(m_dat_o), .s_adr_o(s_adr_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_we_o(s_we_o), .s_sel_o(s_sel_o), .s_dat_o(s_dat_o), .s_ack_i(s_ack_i),
    .s_dat_i(s_dat_i)
  );

  // Slave model: 16-bit memory, programmable wait states, combinational ack
  logic [15:0] mem     [128];
  logic [15:0] ref_mem [128];
  int          waits = 0;
  logic        dead = 1'b0;
  int          wcnt = 0;
  int          s_acks = 0;
  int          s_stbs = 0;
  logic [6:0]  last_adr = '0;
  logic [1:0]  last_sel = '0;
  logic [15:0] last_dat = '0;
  logic        last_we = 1'b0;
  int          n_tests = 0;
  int          n_fail = 0;

  assign s_ack_i = s_cyc_o & s_stb_o & !dead & (wcnt == waits);
  assign s_dat_i = mem[s_adr_o];

  always @(posedge clk_i) begin
    if (s_cyc_o && s_stb_o) begin
      s_stbs <= s_stbs + 1;
      if (s_ack_i) begin
        wcnt     <= 0;
        s_acks   <= s_acks + 1;
        last_adr <= s_adr_o;
        last_sel <= s_sel_o;
        last_dat <= s_dat_o;
        last_we  <= s_we_o;
        if (s_we_o && s_sel_o[0]) mem[s_adr_o][7:0]  <= s_dat_o[7:0];
        if (s_we_o && s_sel_o[1]) mem[s_adr_o][15:8] <= s_dat_o[15:8];
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      wcnt <= 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int halves(input logic [3:0] sel);
    return int'(|sel[1:0]) + int'(|sel[3:2]);
  endfunction

  // Cycles from request acceptance to ack/err
  function automatic int exp_latency(input logic [3:0] sel, input int w, input bit dead_s);
    if (halves(sel) == 0) return 1;
    if (dead_s) return WAIT_MAX + 2;
    return 1 + halves(sel) * (w + 1);
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [5:0] adr, input logic [3:0] sel);
    logic [15:0] lo, hi;
    lo = (|sel[1:0]) ? ref_mem[{adr, 1'b0}] : 16'h0;
    hi = (|sel[3:2]) ? ref_mem[{adr, 1'b1}] : 16'h0;
    return {hi, lo};
  endfunction

  task automatic ref_write(input logic [5:0] adr, input logic [3:0] sel, input logic [31:0] dat);
    if (sel[0]) ref_mem[{adr, 1'b0}][7:0]  = dat[7:0];
    if (sel[1]) ref_mem[{adr, 1'b0}][15:8] = dat[15:8];
    if (sel[2]) ref_mem[{adr, 1'b1}][7:0]  = dat[23:16];
    if (sel[3]) ref_mem[{adr, 1'b1}][15:8] = dat[31:24];
  endtask

  task automatic txn(input string tag, input logic [5:0] adr, input logic we,
                     input logic [3:0] sel, input logic [31:0] dat, input int w, input bit dead_s);
    int          cyc, a0, st0, exp_lat;
    bit          got_ack, got_err, expect_ack;
    logic [31:0] got_dat, err_dat;
    exp_lat    = exp_latency(sel, w, dead_s);
    expect_ack = !dead_s || (halves(sel) == 0);
    waits = w; dead = dead_s;
    a0 = s_acks; st0 = s_stbs;
    m_adr_i = adr; m_we_i = we; m_sel_i = sel; m_dat_i = dat;
    m_cyc_i = 1'b1; m_stb_i = 1'b1;
    cyc = 0; got_ack = 0; got_err = 0; got_dat = '0; err_dat = '0;
    while (!got_ack && !got_err && cyc < 60) begin
      @(posedge clk_i); #1;
      cyc++;
      if (m_ack_o) begin got_ack = 1; got_dat = m_dat_o; end
      if (m_err_o) begin got_err = 1; err_dat = m_dat_o; end
    end
    m_cyc_i = 1'b0; m_stb_i = 1'b0;
    chk({tag, " latency"}, cyc, exp_lat);
    chk({tag, " ack/err"}, {got_ack, got_err}, {expect_ack, !expect_ack});
    if (got_ack && !we) chk({tag, " rdata"}, got_dat, exp_rdata(adr, sel));
    if (got_err) chk({tag, " err dat"}, err_dat, 32'h0);
    chk({tag, " slave acks"}, s_acks - a0, dead_s ? 0 : halves(sel));
    if (halves(sel) == 0) chk({tag, " no stb"}, s_stbs - st0, 0);
    if (we && expect_ack) ref_write(adr, sel, dat);
    @(posedge clk_i); #1;
    chk({tag, " back idle"}, {m_ack_o, m_err_o, s_cyc_o}, 3'b000);
    dead = 1'b0;
  endtask

  initial begin
    int          cyc, t0;
    bit          bad;
    logic [5:0]  r_adr;
    logic        r_we;
    logic [3:0]  r_sel;

    for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);
    mem[0]  = 16'h0113; mem[1]  = 16'h0000;
    mem[2]  = 16'h01B7; mem[3]  = 16'h0010;
    mem[10] = 16'hF06F; mem[11] = 16'hFF5F;
    for (int i = 0; i < 128; i++) ref_mem[i] = mem[i];

    #12;
    chk("reset slave side", {s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o}, 32'h0);
    chk("reset master side", {m_ack_o, m_err_o}, 2'b00);
    chk("reset m_dat_o", m_dat_o, 32'h0);
    @(negedge clk_i); reset_ni = 1'b1;
    @(posedge clk_i); #1;

    txn("rd w0", 6'd0, 1'b0, 4'hF, 32'h0, 0, 1'b0);
    chk("rd w0 halves", last_adr, 7'd1);
    txn("rd w1", 6'd1, 1'b0, 4'hF, 32'h0, 0, 1'b0);

    // Back-to-back: word 5 then word 0 with the request held across DONE
    waits = 0;
    m_adr_i = 6'd5; m_we_i = 1'b0; m_sel_i = 4'hF; m_cyc_i = 1'b1; m_stb_i = 1'b1;
    cyc = 0;
    while (!m_ack_o && cyc < 40) begin @(posedge clk_i); #1; cyc++; end
    chk("b2b first lat", cyc, 3);
    chk("b2b first data", m_dat_o, 32'hFF5FF06F);
    m_adr_i = 6'd0;
    t0 = cyc;
    @(posedge clk_i); #1; cyc++;
    while (!m_ack_o && cyc < 40) begin @(posedge clk_i); #1; cyc++; end
    m_cyc_i = 1'b0; m_stb_i = 1'b0;
    chk("b2b gap", cyc - t0, 4);
    chk("b2b second data", m_dat_o, 32'h00000113);
    @(posedge clk_i); #1;

    txn("wr hi", 6'd3, 1'b1, 4'b1100, 32'hDEADBEEF, 0, 1'b0);
    chk("wr hi fields", {last_adr, last_sel, last_dat, last_we}, {7'd7, 2'b11, 16'hDEAD, 1'b1});
    txn("rd after wr", 6'd3, 1'b0, 4'hF, 32'h0, 0, 1'b0);
    txn("sel0", 6'd9, 1'b0, 4'h0, 32'h0, 0, 1'b0);
    txn("ws3 read", 6'd1, 1'b0, 4'hF, 32'h0, 3, 1'b0);
    txn("timeout", 6'd2, 1'b0, 4'hF, 32'h0, 0, 1'b1);
    txn("after timeout", 6'd5, 1'b0, 4'hF, 32'h0, 1, 1'b0);

    // Abort in HI: 3 wait states puts the second half in flight by cycle 6
    waits = 3;
    m_adr_i = 6'd2; m_we_i = 1'b0; m_sel_i = 4'hF; m_cyc_i = 1'b1; m_stb_i = 1'b1;
    repeat (6) begin @(posedge clk_i); #1; end
    chk("abort in hi", {s_cyc_o, s_adr_o}, {1'b1, 7'd5});
    m_cyc_i = 1'b0; m_stb_i = 1'b0;
    @(posedge clk_i); #1;
    chk("abort s_cyc drop", {s_cyc_o, s_stb_o}, 2'b00);
    bad = 0;
    repeat (20) begin @(posedge clk_i); #1; if (m_ack_o || m_err_o) bad = 1; end
    chk("abort no ack/err", bad, 1'b0);

    // Asynchronous reset in the middle of LO
    m_adr_i = 6'd4; m_we_i = 1'b1; m_sel_i = 4'hF; m_dat_i = 32'h12345678;
    m_cyc_i = 1'b1; m_stb_i = 1'b1;
    repeat (2) begin @(posedge clk_i); #1; end
    chk("pre-reset in lo", {s_cyc_o, s_stb_o, s_we_o}, 3'b111);
    #2 reset_ni = 1'b0;
    #1;
    chk("async rst slave", {s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o}, 32'h0);
    chk("async rst master", {m_ack_o, m_err_o, m_dat_o[0]}, 3'b000);
    m_cyc_i = 1'b0; m_stb_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i); reset_ni = 1'b1;
    bad = 0;
    repeat (4) begin @(posedge clk_i); #1; if (m_ack_o || m_err_o || s_cyc_o) bad = 1; end
    chk("post-reset idle", bad, 1'b0);
    txn("post-reset rd", 6'd1, 1'b0, 4'hF, 32'h0, 0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      r_adr = 6'($urandom_range(0, 63));
      r_we  = ($urandom_range(0, 2) == 0);
      r_sel = 4'($urandom);
      txn(r_we ? "rnd wr" : "rnd rd", r_adr, r_we, r_sel, $urandom, $urandom_range(0, 3), 1'b0);
    end
    for (int k = 0; k < 64; k++) txn("sweep rd", 6'(k), 1'b0, 4'hF, 32'h0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
